// File: rtl/alu_sequencer.sv
// Issue-side sequencer for the ALU: accepts 16-bit register-register instructions,
// reads operands from an 8-entry register file, and writes back the sampled ALU result.
module alu_sequencer #(
  parameter int NREGS = 8,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic          alu_cin,
  output logic [3:0]    alu_ctrl,
  input  logic [DW-1:0] alu_res,
  input  logic          alu_cout,
  input  logic          wr_en,
  input  logic [2:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [2:0]    dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic          carry,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, ISSUE, EXEC, WB} state_t;

  localparam logic [3:0] OP_ADD      = 4'd0;
  localparam logic [3:0] OP_SUB      = 4'd1;
  localparam logic [3:0] OP_LAST_OK  = 4'd8;

  state_t        state_q, state_d;
  logic [15:2]   instr_q, instr_d;
  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];
  logic [DW-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [DW-1:0] res_q, res_d;
  logic [3:0]    alu_ctrl_q, alu_ctrl_d;
  logic          alu_cin_q, alu_cin_d;
  logic          cout_q, cout_d;
  logic          carry_q, carry_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          ready_q, ready_d;
  logic          instr_unused;

  logic [3:0] op;
  logic [2:0] rd, rs, rt;
  logic       use_carry;

  assign op           = instr_q[15:12];
  assign rd           = instr_q[11:9];
  assign rs           = instr_q[8:6];
  assign rt           = instr_q[5:3];
  assign use_carry    = instr_q[2];
  assign instr_unused = ^instr[1:0];

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    regs_d     = regs_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_ctrl_d = alu_ctrl_q;
    alu_cin_d  = alu_cin_q;
    res_d      = res_q;
    cout_d     = cout_q;
    carry_d    = carry_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // External load and a new handshake may land on the same edge; ISSUE then reads the new value.
        if (wr_en) regs_d[wr_addr] = wr_data;
        if (instr_valid && ready_q) begin
          instr_d = instr[15:2];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        alu_a_d    = regs_q[rs];
        alu_b_d    = regs_q[rt];
        alu_ctrl_d = op;
        alu_cin_d  = use_carry & carry_q;
        state_d    = EXEC;
      end
      EXEC: begin
        res_d   = alu_res;
        cout_d  = alu_cout;
        state_d = WB;
      end
      WB: begin
        done_d = 1'b1;
        if (op <= OP_LAST_OK) regs_d[rd] = res_q;
        else                  err_d      = 1'b1;
        if (op == OP_ADD || op == OP_SUB) carry_d = cout_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      instr_q    <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= '0;
      alu_cin_q  <= 1'b0;
      res_q      <= '0;
      cout_q     <= 1'b0;
      carry_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      regs_q     <= regs_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctrl_q <= alu_ctrl_d;
      alu_cin_q  <= alu_cin_d;
      res_q      <= res_d;
      cout_q     <= cout_d;
      carry_q    <= carry_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
    end
  end

  assign instr_ready = ready_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign alu_cin     = alu_cin_q;
  assign carry       = carry_q;
  assign done        = done_q;
  assign err         = err_q;
  assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU on the alu_* pins, a register-file/carry
// reference model, directed scenarios and randomized instruction streams.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        alu_cin, alu_cout;
  logic [3:0]  alu_ctrl;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        carry, done, err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_regs [8];
  logic        m_carry;

  always #5 clk = ~clk;

  alu_sequencer #(.NREGS(8), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_ctrl(alu_ctrl), .alu_res(alu_res), .alu_cout(alu_cout), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .carry(carry), .done(done), .err(err)
  );

  // {carry_out, result} of the ALU; SUB reports a borrow as carry-out.
  function automatic logic [32:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic cin);
    case (op)
      4'd0: return {1'b0, a} + {1'b0, b} + {32'd0, cin};
      4'd1: return {1'b0, a} - {1'b0, b} - {32'd0, cin};
      4'd2: return {1'b0, a & b};
      4'd3: return {1'b0, a | b};
      4'd4: return {1'b0, a ^ b};
      4'd5: return {1'b0, ~a};
      4'd6: return {1'b0, a << b[4:0]};
      4'd7: return {1'b0, 32'($signed(a) >>> b[4:0])};
      4'd8: return {1'b0, a >> b[4:0]};
      default: return {1'b1, 32'hDEAD_BEEF};
    endcase
  endfunction

  always_comb {alu_cout, alu_res} = alu_fn(alu_ctrl, alu_a, alu_b, alu_cin);

  function automatic logic [15:0] mk(input int op, input int rd, input int rs,
                                     input int rt, input bit uc);
    return {4'(op), 3'(rd), 3'(rs), 3'(rt), uc, 2'b00};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic peek(input string tag, input int addr, input logic [31:0] exp);
    dbg_addr = 3'(addr);
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic load(input int addr, input logic [31:0] data);
    wr_en = 1'b1; wr_addr = 3'(addr); wr_data = data;
    @(posedge clk); @(negedge clk);
    wr_en = 1'b0;
    m_regs[addr] = data;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_carry = 1'b0;
  endtask

  // Called just after a negedge with the DUT idle; returns just after the negedge where done shows.
  task automatic issue(input logic [15:0] ins, input bit hold, input bit exec_wr,
                       input bit hs_wr, input int wa, input logic [31:0] wd);
    int n;
    bit seen;
    logic [3:0] op;
    int rd, rs, rt;
    logic cin;
    logic [32:0] r;
    op = ins[15:12]; rd = int'(ins[11:9]); rs = int'(ins[8:6]); rt = int'(ins[5:3]);
    check("ready_before", 32'(instr_ready), 32'd1);
    instr = ins; instr_valid = 1'b1;
    if (hs_wr) begin
      wr_en = 1'b1; wr_addr = 3'(wa); wr_data = wd;
      m_regs[wa] = wd;
    end
    cin = ins[2] & m_carry;
    r = alu_fn(op, m_regs[rs], m_regs[rt], cin);
    @(posedge clk);
    n = 0; seen = 0;
    while (!seen && n < 8) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        if (!hold) instr_valid = 1'b0;
        wr_en = 1'b0;
        check("done_pulse_low", 32'(done), 32'd0);
      end
      if (n == 2) begin
        check("alu_a", alu_a, m_regs[rs]);
        check("alu_b", alu_b, m_regs[rt]);
        check("alu_ctrl", 32'(alu_ctrl), 32'(op));
        check("alu_cin", 32'(alu_cin), 32'(cin));
        if (exec_wr) begin
          wr_en = 1'b1; wr_addr = 3'(rd); wr_data = 32'hBAD0_BAD0;
        end
      end
      if (n == 3) wr_en = 1'b0;
      if (done) seen = 1;
      else if (n <= 3) check("ready_busy", 32'(instr_ready), 32'd0);
    end
    wr_en = 1'b0;
    check("latency", 32'(n), 32'd4);
    check("err", 32'(err), 32'(op > 4'd8));
    check("ready_after", 32'(instr_ready), 32'd1);
    if (op <= 4'd8) m_regs[rd] = r[31:0];
    if (op <= 4'd1) m_carry = r[32];
    check("carry", 32'(carry), 32'(m_carry));
    peek("wb_reg", rd, m_regs[rd]);
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; instr_valid = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; dbg_addr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(instr_ready), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(instr_ready), 32'd1);

    // Test 1: reset during EXEC aborts the write-back
    load(1, 32'd5); load(2, 32'd6);
    instr = mk(0, 3, 1, 2, 0); instr_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t1_ready_in_rst", 32'(instr_ready), 32'd0);
    check("t1_alu_a_rst", alu_a, 32'd0);
    check("t1_alu_b_rst", alu_b, 32'd0);
    begin
      int dcount;
      dcount = 0;
      repeat (3) begin @(negedge clk); if (done) dcount++; end
      rst_n = 1'b1;
      repeat (3) begin @(negedge clk); if (done) dcount++; end
      check("t1_no_done", 32'(dcount), 32'd0);
    end
    model_reset();
    check("t1_ready", 32'(instr_ready), 32'd1);
    check("t1_carry", 32'(carry), 32'd0);
    peek("t1_r3", 3, 32'd0);
    peek("t1_r1", 1, 32'd0);

    // Test 2: ADD carry out, then ADD with carry-in
    load(1, 32'hFFFF_FFFF); load(2, 32'd1);
    issue(mk(0, 3, 1, 2, 0), 0, 0, 0, 0, 0);
    peek("t2_r3", 3, 32'd0);
    check("t2_carry1", 32'(carry), 32'd1);
    issue(mk(0, 4, 2, 2, 1), 0, 0, 0, 0, 0);
    peek("t2_r4", 4, 32'd3);
    check("t2_carry0", 32'(carry), 32'd0);

    // Test 3: SUB borrow, then XOR leaves carry alone
    load(2, 32'd5); load(1, 32'd7);
    issue(mk(1, 5, 2, 1, 0), 0, 0, 0, 0, 0);
    peek("t3_r5", 5, 32'hFFFF_FFFE);
    check("t3_borrow", 32'(carry), 32'd1);
    issue(mk(4, 6, 5, 5, 0), 0, 0, 0, 0, 0);
    peek("t3_r6", 6, 32'd0);
    check("t3_carry_kept", 32'(carry), 32'd1);

    // Test 4: shifts and NOT
    load(1, 32'h8000_0000); load(2, 32'd4);
    issue(mk(7, 7, 1, 2, 0), 0, 0, 0, 0, 0);
    peek("t4_sra", 7, 32'hF800_0000);
    issue(mk(8, 7, 1, 2, 0), 0, 0, 0, 0, 0);
    peek("t4_srl", 7, 32'h0800_0000);
    issue(mk(5, 1, 1, 0, 0), 0, 0, 0, 0, 0);
    peek("t4_not", 1, 32'h7FFF_FFFF);

    // Test 5: illegal opcode
    load(1, 32'hFFFF_FFFF);
    issue(mk(0, 0, 1, 1, 0), 0, 0, 0, 0, 0);
    load(3, 32'h0000_1234);
    issue(mk(11, 3, 1, 1, 0), 0, 0, 0, 0, 0);
    peek("t5_r3", 3, 32'h0000_1234);
    check("t5_carry", 32'(carry), 32'd1);
    issue(mk(3, 4, 3, 1, 0), 0, 0, 0, 0, 0);

    // Test 6: back-to-back with instr_valid held, wr_en during EXEC ignored
    load(1, 32'd3); load(3, 32'h0F0F_0000);
    issue(mk(0, 1, 1, 1, 0), 1, 1, 0, 0, 0);
    peek("t6_r1", 1, 32'd6);
    issue(mk(4, 2, 1, 3, 0), 1, 1, 0, 0, 0);
    issue(mk(1, 4, 1, 2, 0), 0, 0, 0, 0, 0);
    peek("t6_r1_final", 1, 32'd6);

    // Randomized stream, including wr_en coincident with the handshake
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) load(int'($urandom_range(0, 7)), $urandom);
      issue(mk(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom)),
            1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 7)), $urandom);
    end
    for (int i = 0; i < 8; i++) peek("final_reg", i, m_regs[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
